// File: rtl/branch_redirect_ctrl.sv
// EX->IF redirect sequencer: captures branch/exception redirects, hands them to fetch
// over valid/ready and flushes decode. Optional perf counters: BRANCH_REDIRECT_PERF_EN.
`ifndef GRLEN
`define GRLEN 32
`endif

module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_br_valid,
  input  logic                ex_br_taken,
  input  logic [`GRLEN-1:0]   ex_br_target,
  input  logic                exc_valid,
  input  logic [`GRLEN-1:0]   exc_target,
  input  logic                fe_redirect_ready,
  output logic                fe_redirect_valid,
  output logic [`GRLEN-1:0]   fe_redirect_target,
  output logic                flush_de,
  output logic                ex_stall,
  output logic                busy,
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_flush_cycles
);

  localparam int unsigned GW = `GRLEN;
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   target_q, target_d;
  logic [3:0]      cnt_q, cnt_d;

  function automatic logic [GW-1:0] word_align(input logic [GW-1:0] t);
    return {t[GW-1:2], 2'b00};
  endfunction

  // State, latched target and drain counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; exceptions always win over branches
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          target_d = word_align(exc_target);
          state_d  = ST_REQ;
        end else if (ex_br_valid && ex_br_taken) begin
          target_d = word_align(ex_br_target);
          state_d  = ST_REQ;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Target may only change while fetch has not yet taken it
        if (fe_redirect_ready) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_DRAIN;
        end else if (exc_valid) begin
          target_d = word_align(exc_target);
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (exc_valid) begin
          target_d = word_align(exc_target);
          state_d  = ST_REQ;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fe_redirect_valid  = (state_q == ST_REQ);
  assign fe_redirect_target = target_q;
  assign ex_stall           = (state_q == ST_REQ);
  assign flush_de           = (state_q != ST_IDLE);
  assign busy               = (state_q != ST_IDLE);

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [31:0] perf_redirects_q;
  logic [31:0] perf_flush_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_redirects_q <= 32'd0;
      perf_flush_q     <= 32'd0;
    end else begin
      if (fe_redirect_valid && fe_redirect_ready) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end else begin
        perf_redirects_q <= perf_redirects_q;
      end
      if (flush_de) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end else begin
        perf_flush_q <= perf_flush_q;
      end
    end
  end

  assign perf_redirects    = perf_redirects_q;
  assign perf_flush_cycles = perf_flush_q;
`else
  assign perf_redirects    = 32'd0;
  assign perf_flush_cycles = 32'd0;
`endif

endmodule
